cic_frame_scheduler: RTL and testbench

CIC_FRAME_SCHEDULER -- requirements
Module: cic_frame_scheduler

---
 rtl/cic_frame_scheduler.sv | 129 ++++++++++++
 tb/tb_cic_frame_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cic_frame_scheduler.sv
// rtl/cic_frame_scheduler.sv - ping-pong 16-channel sample-to-frame scheduler feeding the CIC filter input
// Optional sequence checking on s_channel is compiled in when CIC_FRAME_SCHED_SEQCHK_EN is defined.
module cic_frame_scheduler (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [15:0]  s_data,
    input  logic [3:0]   s_channel,
    input  logic [1:0]   s_error,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [255:0] m_data,
    output logic [1:0]   m_error,
    output logic         seq_err
);

    logic [15:0] mem_q [2][16];
    logic [1:0]  full_q, full_d;
    logic        fill_q, fill_d;
    logic        pres_q, pres_d;
    logic [3:0]  exp_ch_q, exp_ch_d;
    logic [1:0]  err_acc_q [2];
    logic [1:0]  err_acc_d [2];
    logic        m_valid_q;
    logic        seq_err_q, seq_err_d;
    logic        wr_en;
    logic [3:0]  wr_slot;
    logic        s_xfer, m_xfer, frame_done;

    // Only the fill bank can be written, and it is full only when both banks are full.
    assign s_ready = ~(full_q[0] & full_q[1]);
    assign s_xfer  = s_valid & s_ready;
    assign m_xfer  = m_valid_q & m_ready;

`ifdef CIC_FRAME_SCHED_SEQCHK_EN
    always_comb begin
        wr_en     = s_xfer;
        wr_slot   = exp_ch_q;
        exp_ch_d  = exp_ch_q;
        seq_err_d = 1'b0;
        if (s_xfer) begin
            if (s_channel != exp_ch_q) begin
                // Out of order: abandon the partial fill; a channel-0 sample restarts it.
                seq_err_d = 1'b1;
                if (s_channel == 4'd0) begin
                    wr_slot  = 4'd0;
                    exp_ch_d = 4'd1;
                end else begin
                    wr_en    = 1'b0;
                    exp_ch_d = 4'd0;
                end
            end else begin
                exp_ch_d = exp_ch_q + 4'd1;
            end
        end
    end
`else
    logic unused_channel;
    assign unused_channel = ^s_channel;

    always_comb begin
        wr_en     = s_xfer;
        wr_slot   = exp_ch_q;
        exp_ch_d  = s_xfer ? exp_ch_q + 4'd1 : exp_ch_q;
        seq_err_d = 1'b0;
    end
`endif

    assign frame_done = wr_en & (wr_slot == 4'hF);

    always_comb begin
        full_d = full_q;
        if (m_xfer) begin
            full_d[pres_q] = 1'b0;
        end
        if (frame_done) begin
            full_d[fill_q] = 1'b1;
        end
        fill_d = fill_q ^ frame_done;
        pres_d = pres_q ^ m_xfer;

        err_acc_d[0] = err_acc_q[0];
        err_acc_d[1] = err_acc_q[1];
        if (wr_en) begin
            err_acc_d[fill_q] = (wr_slot == 4'd0) ? s_error : (err_acc_q[fill_q] | s_error);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q       <= 2'b00;
            fill_q       <= 1'b0;
            pres_q       <= 1'b0;
            exp_ch_q     <= 4'd0;
            err_acc_q[0] <= 2'b00;
            err_acc_q[1] <= 2'b00;
            m_valid_q    <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            full_q       <= full_d;
            fill_q       <= fill_d;
            pres_q       <= pres_d;
            exp_ch_q     <= exp_ch_d;
            err_acc_q[0] <= err_acc_d[0];
            err_acc_q[1] <= err_acc_d[1];
            m_valid_q    <= full_d[pres_d];
            seq_err_q    <= seq_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[fill_q][wr_slot] <= s_data;
        end
    end

    always_comb begin
        m_data = '0;
        for (int k = 0; k < 16; k++) begin
            m_data[16*k +: 16] = m_valid_q ? mem_q[pres_q][k] : 16'h0000;
        end
    end

    assign m_valid = m_valid_q;
    assign m_error = m_valid_q ? err_acc_q[pres_q] : 2'b00;
    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_cic_frame_scheduler.sv
// tb/tb_cic_frame_scheduler.sv - directed self-checking bench for cic_frame_scheduler
module tb_cic_frame_scheduler;

    logic         clk;
    logic         reset;
    logic         s_valid;
    logic         s_ready;
    logic [15:0]  s_data;
    logic [3:0]   s_channel;
    logic [1:0]   s_error;
    logic         m_valid;
    logic         m_ready;
    logic [255:0] m_data;
    logic [1:0]   m_error;
    logic         seq_err;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    logic [255:0] exp_frame;

    cic_frame_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_channel (s_channel),
        .s_error   (s_error),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_error   (m_error),
        .seq_err   (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [255:0] ramp(input logic [15:0] base);
        logic [255:0] f;
        f = '0;
        for (int k = 0; k < 16; k++) f[16*k +: 16] = base + 16'(k);
        return f;
    endfunction

    task automatic send(input logic [3:0] ch, input logic [15:0] d, input logic [1:0] e);
        s_valid   = 1'b1;
        s_channel = ch;
        s_data    = d;
        s_error   = e;
        @(posedge clk);
        #1;
        s_valid   = 1'b0;
        s_error   = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = '0; s_channel = '0; s_error = '0; m_ready = 1'b1;
        tick();
        tick();
        check("rst_m_valid", {255'b0, m_valid}, 256'd0);
        check("rst_s_ready", {255'b0, s_ready}, 256'd1);
        check("rst_seq_err", {255'b0, seq_err}, 256'd0);
        check("rst_m_error", {254'b0, m_error}, 256'd0);
        check("rst_m_data", m_data, 256'd0);
        reset = 1'b0;
        tick();

        // Basic frame, m_ready high
        for (int k = 0; k < 15; k++) send(4'(k), 16'h1000 + 16'(k), 2'b00);
        check("t1_no_early_valid", {255'b0, m_valid}, 256'd0);
        send(4'd15, 16'h100F, 2'b00);
        check("t1_m_valid", {255'b0, m_valid}, 256'd1);
        check("t1_m_data", m_data, ramp(16'h1000));
        check("t1_m_error", {254'b0, m_error}, 256'd0);
        tick();
        check("t1_single_cycle", {255'b0, m_valid}, 256'd0);
        check("t1_data_gated", m_data, 256'd0);

        // Backpressure: two frames held, third waits
        m_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            send(4'(i % 16), 16'h2000 + 16'(i), 2'b00);
            if (i == 15) begin
                check("t2_f1_valid", {255'b0, m_valid}, 256'd1);
                check("t2_f1_data", m_data, ramp(16'h2000));
                check("t2_ready_after16", {255'b0, s_ready}, 256'd1);
            end
        end
        check("t2_s_ready_low", {255'b0, s_ready}, 256'd0);
        check("t2_f1_held", m_data, ramp(16'h2000));
        s_valid = 1'b1; s_channel = 4'd0; s_data = 16'h2020;
        tick();
        check("t2_still_blocked", {255'b0, s_ready}, 256'd0);
        check("t2_f1_stable", m_data, ramp(16'h2000));
        m_ready = 1'b1;
        tick();
        check("t2_f2_valid", {255'b0, m_valid}, 256'd1);
        check("t2_f2_data", m_data, ramp(16'h2010));
        check("t2_s_ready_high", {255'b0, s_ready}, 256'd1);
        tick();
        s_valid = 1'b0;
        check("t2_f2_single", {255'b0, m_valid}, 256'd0);
        for (int i = 33; i < 48; i++) send(4'(i % 16), 16'h2000 + 16'(i), 2'b00);
        check("t2_f3_valid", {255'b0, m_valid}, 256'd1);
        check("t2_f3_data", m_data, ramp(16'h2020));
        tick();

        // Error accumulation
        for (int k = 0; k < 16; k++)
            send(4'(k), 16'h3000 + 16'(k), (k == 3) ? 2'b01 : (k == 9) ? 2'b10 : 2'b00);
        check("t3_fa_valid", {255'b0, m_valid}, 256'd1);
        check("t3_fa_error", {254'b0, m_error}, 256'd3);
        for (int k = 0; k < 16; k++) send(4'(k), 16'h3100 + 16'(k), 2'b00);
        check("t3_fb_valid", {255'b0, m_valid}, 256'd1);
        check("t3_fb_error", {254'b0, m_error}, 256'd0);
        check("t3_fb_data", m_data, ramp(16'h3100));
        tick();

        // Out-of-order channel
        for (int k = 0; k < 5; k++) send(4'(k), 16'h4000 + 16'(k), 2'b00);
        send(4'd7, 16'h4007, 2'b00);
`ifdef CIC_FRAME_SCHED_SEQCHK_EN
        check("t4_seq_err_pulse", {255'b0, seq_err}, 256'd1);
        check("t4_no_frame", {255'b0, m_valid}, 256'd0);
        tick();
        check("t4_seq_err_clear", {255'b0, seq_err}, 256'd0);
        for (int k = 0; k < 16; k++) begin
            send(4'(k), 16'h4100 + 16'(k), 2'b00);
            if (k == 14) check("t4_no_early_frame", {255'b0, m_valid}, 256'd0);
        end
        check("t4_frame_valid", {255'b0, m_valid}, 256'd1);
        check("t4_frame_data", m_data, ramp(16'h4100));
        check("t4_seq_err_quiet", {255'b0, seq_err}, 256'd0);
`else
        check("t4_seq_err_tied", {255'b0, seq_err}, 256'd0);
        exp_frame = '0;
        for (int k = 0; k < 5; k++) exp_frame[16*k +: 16] = 16'h4000 + 16'(k);
        exp_frame[16*5 +: 16] = 16'h4007;
        for (int k = 6; k < 16; k++) exp_frame[16*k +: 16] = 16'h4100 + 16'(k - 6);
        for (int k = 0; k < 16; k++) begin
            send(4'(k), 16'h4100 + 16'(k), 2'b00);
            if (k == 8) check("t4_no_early_frame", {255'b0, m_valid}, 256'd0);
            if (k == 9) begin
                check("t4_frame_valid", {255'b0, m_valid}, 256'd1);
                check("t4_frame_data", m_data, exp_frame);
            end
            if (k == 10) check("t4_frame_single", {255'b0, m_valid}, 256'd0);
        end
        check("t4_seq_err_quiet", {255'b0, seq_err}, 256'd0);
`endif
        tick();

        // Reset mid-frame with a pending frame
        do_reset();
        m_ready = 1'b0;
        for (int k = 0; k < 16; k++) send(4'(k), 16'h5000 + 16'(k), 2'b00);
        for (int k = 0; k < 9; k++) send(4'(k), 16'h5100 + 16'(k), 2'b00);
        check("t5_pending", {255'b0, m_valid}, 256'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_m_valid", {255'b0, m_valid}, 256'd0);
        check("t5_rst_s_ready", {255'b0, s_ready}, 256'd1);
        check("t5_rst_m_data", m_data, 256'd0);
        tick();
        reset = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            send(4'(k), 16'h5200 + 16'(k), 2'b00);
            if (k == 14) check("t5_no_early_frame", {255'b0, m_valid}, 256'd0);
        end
        check("t5_frame_valid", {255'b0, m_valid}, 256'd1);
        check("t5_frame_data", m_data, ramp(16'h5200));
        tick();
        check("t5_frame_single", {255'b0, m_valid}, 256'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
